// File: rtl/seq_pkg.sv
// Shared types and constants for the run sequencer and its sub-blocks.
package seq_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CORE_RST,
        RUN,
        DRAIN,
        DONE
    } seq_state_t;

endpackage

// File: rtl/run_sequencer_if.sv
// Sequencer-side bundle: load stream, data-memory port, core control and result stream.
// master = the sequencer, slave = the surrounding host/core/memory environment.
interface run_sequencer_if #(
    parameter int AW = 8
);
    import seq_pkg::*;

    logic              start;
    logic              in_valid;
    logic [BYTE_W-1:0] in_data;
    logic              in_ready;
    logic              dm_own;
    logic              dm_wr_en;
    logic [AW-1:0]     dm_addr;
    logic [BYTE_W-1:0] dm_wr_data;
    logic [BYTE_W-1:0] dm_rd_data;
    logic              core_reset;
    logic              core_req;
    logic              core_done;
    logic              out_valid;
    logic [BYTE_W-1:0] out_data;
    logic              out_ready;
    logic              busy;
    logic              finished;
    logic              err;

    modport master (
        input  start, in_valid, in_data, dm_rd_data, core_done, out_ready,
        output in_ready, dm_own, dm_wr_en, dm_addr, dm_wr_data, core_reset,
               core_req, out_valid, out_data, busy, finished, err
    );

    modport slave (
        output start, in_valid, in_data, dm_rd_data, core_done, out_ready,
        input  in_ready, dm_own, dm_wr_en, dm_addr, dm_wr_data, core_reset,
               core_req, out_valid, out_data, busy, finished, err
    );

endinterface

// File: rtl/run_sequencer_xfer_counter.sv
// Transfer counter shared by the load and drain phases; sel_i picks the drain window.
module xfer_counter #(
    parameter int AW        = 8,
    parameter int LOAD_BASE = 0,
    parameter int LOAD_LEN  = 64,
    parameter int RES_BASE  = 64,
    parameter int RES_LEN   = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_i,
    input  logic          step_i,
    input  logic          sel_i,
    output logic [AW-1:0] addr_o,
    output logic          last_o
);

    localparam logic [AW-1:0] LOAD_B    = AW'(LOAD_BASE);
    localparam logic [AW-1:0] RES_B     = AW'(RES_BASE);
    localparam logic [AW:0]   LOAD_LAST = (AW+1)'(LOAD_LEN - 1);
    localparam logic [AW:0]   RES_LAST  = (AW+1)'(RES_LEN - 1);

    logic [AW:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (step_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Address arithmetic wraps modulo 2**AW; the top rejects windows that would wrap.
    assign addr_o = (sel_i ? RES_B : LOAD_B) + cnt_q[AW-1:0];
    assign last_o = (cnt_q == (sel_i ? RES_LAST : LOAD_LAST));

endmodule

// File: rtl/run_sequencer.sv
// Host-side run controller: load operands, reset/release the core, drain results.
// Optional RUN-state watchdog enabled by defining RUN_TIMEOUT_EN.
//
// state    | meaning
// IDLE     | waiting for start; core held in reset, sequencer owns memory
// LOAD     | accepting operand bytes into data memory
// CORE_RST | one cycle of core reset before release
// RUN      | core owns memory; req on first cycle, wait for done
// DRAIN    | streaming result bytes out of data memory
// DONE     | one-cycle finished pulse
module run_sequencer
    import seq_pkg::*;
#(
    parameter int AW        = 8,
    parameter int LOAD_BASE = 0,
    parameter int LOAD_LEN  = 64,
    parameter int RES_BASE  = 64,
    parameter int RES_LEN   = 32,
    parameter int TIMEOUT   = 4096
) (
    input logic             clk,
    input logic             reset,
    run_sequencer_if.master bus
);

    if (LOAD_LEN < 1 || LOAD_BASE + LOAD_LEN > 2**AW) begin : g_bad_load
        $error("run_sequencer: load window does not fit in data memory");
    end
    if (RES_LEN < 1 || RES_BASE + RES_LEN > 2**AW) begin : g_bad_res
        $error("run_sequencer: result window does not fit in data memory");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("run_sequencer: TIMEOUT must be at least 1");
    end

    localparam logic [2:0] ST_IDLE     = 3'(IDLE);
    localparam logic [2:0] ST_LOAD     = 3'(LOAD);
    localparam logic [2:0] ST_CORE_RST = 3'(CORE_RST);
    localparam logic [2:0] ST_RUN      = 3'(RUN);
    localparam logic [2:0] ST_DRAIN    = 3'(DRAIN);
    localparam logic [2:0] ST_DONE     = 3'(DONE);

    logic [2:0]    state_q, state_d;
    logic          run_first_q;
    logic          in_ready, in_hs, out_valid, out_hs, in_run;
    logic          done_ok, timeout;
    logic          cnt_clear, cnt_last;
    logic [AW-1:0] cnt_addr;

    // Handshake-facing outputs are gated by reset so nothing is written while it is low.
    assign in_ready  = reset && (state_q == ST_LOAD);
    assign out_valid = reset && (state_q == ST_DRAIN);
    assign in_run    = reset && (state_q == ST_RUN);
    assign in_hs     = in_ready && bus.in_valid;
    assign out_hs    = out_valid && bus.out_ready;
    assign done_ok   = !run_first_q && bus.core_done;

`ifdef RUN_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] wdog_q, wdog_d;
    logic          err_q, err_d;

    assign timeout = (state_q == ST_RUN) && (wdog_q == '0) && !done_ok;

    always_comb begin
        wdog_d = wdog_q;
        err_d  = err_q;
        if (state_q == ST_CORE_RST) begin
            wdog_d = TW'(TIMEOUT - 1);
        end else if (state_q == ST_RUN && wdog_q != '0) begin
            wdog_d = wdog_q - 1'b1;
        end
        if (state_q == ST_IDLE && bus.start) begin
            err_d = 1'b0;
        end else if (timeout) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            err_q  <= err_d;
        end
    end

    assign bus.err = err_q;
`else
    assign timeout = 1'b0;
    assign bus.err = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_clear = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d   = ST_LOAD;
                    cnt_clear = 1'b1;
                end
            end
            ST_LOAD:     if (in_hs && cnt_last) state_d = ST_CORE_RST;
            ST_CORE_RST: state_d = ST_RUN;
            ST_RUN: begin
                if (done_ok || timeout) begin
                    state_d   = ST_DRAIN;
                    cnt_clear = 1'b1;
                end
            end
            ST_DRAIN:    if (out_hs && cnt_last) state_d = ST_DONE;
            ST_DONE:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            run_first_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_first_q <= (state_q == ST_CORE_RST);
        end
    end

    xfer_counter #(
        .AW        (AW),
        .LOAD_BASE (LOAD_BASE),
        .LOAD_LEN  (LOAD_LEN),
        .RES_BASE  (RES_BASE),
        .RES_LEN   (RES_LEN)
    ) u_xfer (
        .clk_i   (clk),
        .rst_ni  (reset),
        .clear_i (cnt_clear),
        .step_i  (in_hs || out_hs),
        .sel_i   (state_q == ST_DRAIN),
        .addr_o  (cnt_addr),
        .last_o  (cnt_last)
    );

    assign bus.in_ready   = in_ready;
    assign bus.dm_wr_en   = in_hs;
    assign bus.dm_addr    = (in_ready || out_valid) ? cnt_addr : '0;
    assign bus.dm_wr_data = in_ready ? bus.in_data : '0;
    assign bus.dm_own     = !in_run;
    assign bus.core_reset = !in_run;
    assign bus.core_req   = in_run && run_first_q;
    assign bus.out_valid  = out_valid;
    assign bus.out_data   = out_valid ? bus.dm_rd_data : '0;
    assign bus.busy       = reset && (state_q != ST_IDLE);
    assign bus.finished   = reset && (state_q == ST_DONE);

endmodule

// File: tb/tb_run_sequencer.sv
// Scoreboard bench for run_sequencer: memory and core models, randomized operands,
// expected result bytes queued at stimulus time and popped by a negedge monitor.
module tb_run_sequencer;
    import seq_pkg::*;

    localparam int AW        = 8;
    localparam int LOAD_BASE = 0;
    localparam int LOAD_LEN  = 64;
    localparam int RES_BASE  = 64;
    localparam int RES_LEN   = 32;
    localparam int TIMEOUT   = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;

    run_sequencer_if #(.AW(AW)) bus ();

    run_sequencer #(
        .AW(AW), .LOAD_BASE(LOAD_BASE), .LOAD_LEN(LOAD_LEN),
        .RES_BASE(RES_BASE), .RES_LEN(RES_LEN), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:255];
    assign bus.dm_rd_data = mem[bus.dm_addr];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0, last_wr_cyc = 0;
    int wr_cnt = 0, req_cnt = 0, fin_cnt = 0, out_cnt = 0, run_cyc_cnt = 0;
    int core_mode = 0;  // 0: leave memory, 1: pair sums, 2: never complete
    int rdy_mode = 0;   // 0: always ready, 1: 1,0,0,1 pattern, 2: random
    logic prev_fin = 1'b0, prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic [7:0] sb_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: memory writes, event counters and scoreboard checks.
    always @(negedge clk) begin
        cyc++;
        if (bus.dm_wr_en) begin
            if (bus.dm_own) mem[bus.dm_addr] = bus.dm_wr_data;
            wr_cnt++;
            last_wr_cyc = cyc;
        end
        if (bus.core_req) begin
            req_cnt++;
            chk("req_after_last_write", 32'(cyc - last_wr_cyc), 32'd2);
        end
        if (!bus.dm_own) run_cyc_cnt++;
        if (prev_fin) chk("busy_after_finished", {31'd0, bus.busy}, 32'd0);
        if (bus.finished) fin_cnt++;
        prev_fin = bus.finished;
        if (bus.out_valid) begin
            if (prev_stall) chk("out_data_stable", {24'd0, bus.out_data}, {24'd0, prev_data});
            if (bus.out_ready) begin
                out_cnt++;
                if (sb_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL out_unexpected: got %0h expected no byte", bus.out_data);
                end else begin
                    chk("out_byte", {24'd0, bus.out_data}, {24'd0, sb_q.pop_front()});
                end
            end
        end
        prev_stall = reset && bus.out_valid && !bus.out_ready;
        prev_data  = bus.out_data;
    end

    // Core model: on req, optionally compute results, then signal done 10 cycles later.
    initial begin
        bus.core_done = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.core_req) begin
                if (core_mode == 1) begin
                    for (int i = 0; i < RES_LEN; i++)
                        mem[RES_BASE+i] = 8'(mem[LOAD_BASE+2*i] + mem[LOAD_BASE+2*i+1]);
                end
                if (core_mode != 2) begin
                    repeat (9) @(posedge clk);
                    #1 bus.core_done = 1'b1;
                    @(posedge clk);
                    #1 bus.core_done = 1'b0;
                end
            end
        end
    end

    // Output consumer.
    initial begin
        int k = 0;
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = ((k % 4) == 0) || ((k % 4) == 3);
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
            k++;
        end
    end

    task automatic do_start();
        @(posedge clk);
        #1 bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic load_bytes(input logic [7:0] b[$], input int n);
        int i = 0, c = 0, guard = 0;
        while (i < n && guard < 2000) begin
            @(posedge clk);
            #1;
            bus.in_valid = ((c % 3) != 2);
            bus.in_data  = b[i];
            c++;
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) i++;
            guard++;
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        if (i < n) begin
            n_chk++;
            n_fail++;
            $display("FAIL load_timeout: got %0d bytes accepted expected %0d", i, n);
        end
    endtask

    task automatic run_case(input logic [7:0] b[$], input logic [7:0] exp[$], input int cmode,
                            input int rmode, input int exp_run, input logic exp_err,
                            input logic keep_start);
        int w0, r0, f0, o0, c0, n;
        core_mode = cmode;
        rdy_mode  = rmode;
        foreach (exp[i]) sb_q.push_back(exp[i]);
        w0 = wr_cnt; r0 = req_cnt; f0 = fin_cnt; o0 = out_cnt; c0 = run_cyc_cnt;
        if (!bus.start) do_start();
        load_bytes(b, LOAD_LEN);
        if (!keep_start) bus.start = 1'b0;
        chk("err_after_start", {31'd0, bus.err}, 32'd0);
        for (int i = 0; i < LOAD_LEN; i++)
            chk("mem_load", {24'd0, mem[LOAD_BASE+i]}, {24'd0, b[i]});
        n = 0;
        while (fin_cnt == f0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (fin_cnt == f0) begin
            n_chk++;
            n_fail++;
            $display("FAIL finished_timeout: got no finished pulse within %0d cycles", n);
        end
        @(negedge clk);
        chk("write_count", 32'(wr_cnt - w0), 32'(LOAD_LEN));
        chk("req_count", 32'(req_cnt - r0), 32'd1);
        chk("finished_count", 32'(fin_cnt - f0), 32'd1);
        chk("out_count", 32'(out_cnt - o0), 32'(RES_LEN));
        chk("run_cycles", 32'(run_cyc_cnt - c0), 32'(exp_run));
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        chk("err_at_end", {31'd0, bus.err}, {31'd0, exp_err});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no end of test expected $finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [7:0] b[$];
        logic [7:0] exp[$];
        logic [7:0] exp_d[$];
        int w0;

        bus.start = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        for (int i = 0; i < RES_LEN; i++) mem[RES_BASE+i] = 8'(8'hA0 + i);

        // Power-on reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_core_reset", {31'd0, bus.core_reset}, 32'd1);
        chk("rst_dm_own", {31'd0, bus.dm_own}, 32'd1);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_dm_wr_en", {31'd0, bus.dm_wr_en}, 32'd0);
        chk("rst_core_req", {31'd0, bus.core_req}, 32'd0);
        chk("rst_finished", {31'd0, bus.finished}, 32'd0);
        chk("rst_err", {31'd0, bus.err}, 32'd0);
        chk("rst_dm_addr", {24'd0, bus.dm_addr}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;

        // Reset in the middle of LOAD.
        b.delete();
        for (int i = 0; i < LOAD_LEN; i++) b.push_back(8'($urandom));
        w0 = wr_cnt;
        do_start();
        load_bytes(b, 20);
        chk("partial_write_count", 32'(wr_cnt - w0), 32'd20);
        w0 = wr_cnt;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h55;
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("midrst_core_reset", {31'd0, bus.core_reset}, 32'd1);
            chk("midrst_dm_own", {31'd0, bus.dm_own}, 32'd1);
            chk("midrst_dm_wr_en", {31'd0, bus.dm_wr_en}, 32'd0);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("midrst_idle", {31'd0, bus.busy}, 32'd0);
        end
        chk("no_write_after_reset", 32'(wr_cnt - w0), 32'd0);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;

        // Run A: incrementing operands, preloaded results, consumer always ready.
        b.delete();
        exp.delete();
        for (int i = 0; i < LOAD_LEN; i++) b.push_back(8'(i));
        for (int i = 0; i < RES_LEN; i++) exp.push_back(8'(8'hA0 + i));
        run_case(b, exp, 0, 0, 10, 1'b0, 1'b0);

        // Run B: random operands, pair-sum results, stalling consumer 1,0,0,1.
        b.delete();
        exp.delete();
        for (int i = 0; i < LOAD_LEN; i++) b.push_back(8'($urandom));
        for (int i = 0; i < RES_LEN; i++) exp.push_back(8'(b[2*i] + b[2*i+1]));
        run_case(b, exp, 1, 1, 10, 1'b0, 1'b0);

        // Runs C and D: start held through RUN and DONE, back-to-back runs.
        b.delete();
        exp.delete();
        for (int i = 0; i < LOAD_LEN; i++) b.push_back(8'($urandom));
        for (int i = 0; i < RES_LEN; i++) exp.push_back(8'(b[2*i] + b[2*i+1]));
        @(posedge clk);
        #1 bus.start = 1'b1;
        run_case(b, exp, 1, 2, 10, 1'b0, 1'b1);
        @(negedge clk);
        chk("second_run_started", {31'd0, bus.busy}, 32'd1);
        b.delete();
        exp_d.delete();
        for (int i = 0; i < LOAD_LEN; i++) b.push_back(8'($urandom));
        for (int i = 0; i < RES_LEN; i++) exp_d.push_back(8'(b[2*i] + b[2*i+1]));
        run_case(b, exp_d, 1, 2, 10, 1'b0, 1'b0);

`ifdef RUN_TIMEOUT_EN
        // Run E: core never completes; watchdog drains the previous run's results.
        b.delete();
        for (int i = 0; i < LOAD_LEN; i++) b.push_back(8'($urandom));
        run_case(b, exp_d, 2, 2, TIMEOUT, 1'b1, 1'b0);
        // Run F: the next start clears err and a normal run follows.
        exp.delete();
        for (int i = 0; i < RES_LEN; i++) exp.push_back(8'(b[2*i] + b[2*i+1]));
        run_case(b, exp, 1, 0, 10, 1'b0, 1'b0);
`endif

        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
